spi_slave_regif: RTL and testbench
==================================

// Module: spi_slave_regif
// PURPOSE
// SPI responder (slave) for the team's 2-byte SPI frame: CSN low, 8-bit address byte, 8-bit data byte.
// It oversamples SCLK, CSN and MOSI on i_ck and turns each frame into a register-file access on a simple parallel bus.
// It returns the addressed register's contents on MISO during the data byte.
// It sits at the device end of the link, opposite spi_master, and lets the I2C-to-SPI bridge be looped back and verified on-chip.
// PARAMETERS
// LSB_FIRST   0   1: address, data and MISO bytes are shifted LSB first; 0: MSB first
// SYNC_STAGES 2   synchroniser depth for i_sclk, i_csn and i_mosi (minimum 2)
// PORTS
// i_ck        in   1  system clock (100 MHz)
// i_rstn      in   1  asynchronous, active-low reset
// i_sclk      in   1  SPI clock from master, idles high (CPOL=1)
// i_csn       in   1  chip select, active low
// i_mosi      in   1  master-out data
// o_miso      out  1  slave-out data
// o_miso_oe   out  1  MISO output enable; high only while CSN is low (synchronised)
// o_addr      out  8  register address, held from address-byte completion until the next frame
// o_rd        out  1  one-cycle read strobe
// i_rdata     in   8  read data, sampled exactly 1 i_ck after o_rd
// o_wr        out  1  one-cycle write strobe
// o_wdata     out  8  write data, valid while o_wr is high and held afterwards
// o_frame_err out  1  one-cycle pulse: CSN rose with a bit count other than 0 or 16
// o_busy      out  1  high while in any state other than IDLE
// BEHAVIOUR
// - Reset values: o_miso=0, o_miso_oe=0, o_addr=0, o_wdata=0; o_rd, o_wr, o_frame_err, o_busy all 0.
//   Synchroniser stages reset to SCLK=1, CSN=1. State=IDLE, bit_cnt=0.
// - Inputs pass through SYNC_STAGES flops. Rise/fall are detected on the synchronised SCLK; events act 1 cycle after detection.
// - Mode 3 timing:
//   - MOSI is sampled on SCLK rising edges.
//   - o_miso is updated on SCLK falling edges only.
//   - Master SCLK half-period must be at least SYNC_STAGES+4 i_ck cycles.
// - FSM states: IDLE, ADDR, FETCH, DATA, DONE.
//   - IDLE: CSN falls -> ADDR; bit_cnt=0; o_miso_oe=1; o_miso=0.
//   - ADDR: each rise shifts MOSI into addr_sr and increments bit_cnt.
//     At bit_cnt=8: o_addr<=addr_sr, o_rd=1 for one cycle, go to FETCH.
//   - FETCH: 1 cycle later load i_rdata into tx_sr (bit-reversed if LSB_FIRST), go to DATA.
//   - DATA:
//     - each fall drives the next tx_sr bit onto o_miso; the first fall of DATA drives bit 7 (bit 0 if LSB_FIRST);
//     - each rise shifts MOSI into rx_sr and increments bit_cnt;
//     - at bit_cnt=16: o_wdata<=rx_sr. If o_addr[7]==0, o_wr=1 for one cycle (addr[7]=1 means read-only access, no write). Go to DONE.
//   - DONE: further SCLK edges are ignored; no second o_wr; o_miso holds its last bit.
// - CSN rises in any state -> IDLE next cycle; o_miso_oe=0, o_miso=0.
//   - If bit_cnt is not 0 and not 16: o_frame_err pulses and no o_wr is issued (abort).
//   - If abort lands after o_rd: the read has already happened; that is allowed.
// - CSN falling and SCLK edge in the same cycle: the SCLK edge is ignored (master idles SCLK high before CSN).
// - bit_cnt is 5 bits; it saturates at 16 and never wraps.
// - o_rd and o_wr are never high in the same cycle. Each is at most one pulse per frame.
// - i_rstn asserted mid-frame: everything returns to reset values immediately; no strobes.
// TESTING
// - Frame 0x12 addr, 0xA5 data, MSB first, i_rdata=0x3C, master CLK_CNT=40:
//   one o_rd with o_addr=0x12; MISO bits on master rises read 0x3C; one o_wr with o_wdata=0xA5.
// - Addr 0x85, data 0x77: o_rd issued and MISO returns i_rdata; o_wr never asserts; o_wdata=0x77.
// - LSB_FIRST=1, addr byte sent as 0x48 (LSB first, meaning 0x12), i_rdata=0x01:
//   o_addr=0x12; first MISO bit=1, remaining seven bits=0.
// - CSN deasserted after 11 bits: o_frame_err pulses once; no o_wr; o_busy=0 within SYNC_STAGES+2 cycles.
// - 20 SCLK pulses in one frame: exactly one o_wr, carrying bits 9-16; no o_frame_err.
// - i_rstn pulsed low during the data byte: all outputs return to reset values.
//   The next clean frame (0x01/0xFF) completes normally with o_wr, o_wdata=0xFF.

Source files
------------

// File: rtl/spi_slave_regif.sv
// spi_slave_regif: oversampled mode-3 SPI responder turning 2-byte frames into register reads/writes.
// Revision 1.0 - initial release.
`default_nettype none

module spi_slave_regif #(
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_ck,
  input  logic       i_rstn,
  input  logic       i_sclk,
  input  logic       i_csn,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  output logic [7:0] o_addr,
  output logic       o_rd,
  input  logic [7:0] i_rdata,
  output logic       o_wr,
  output logic [7:0] o_wdata,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    FETCH = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
  logic sclk_s, csn_s, mosi_s;
  logic sclk_prev, csn_prev;
  logic rise_q, fall_q, csn_fall_q, csn_rise_q, mosi_q;
  logic [4:0] bit_cnt;
  logic [7:0] addr_sr, rx_sr, tx_sr;
  logic start, stop, rd_go, wr_go, err_go, tx_load, wdata_load;
  logic shift_en;

  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
    if (LSB_FIRST != 0) return {b, sr[7:1]};
    else                return {sr[6:0], b};
  endfunction

  function automatic logic [7:0] bit_rev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edges are registered so they act one cycle after detection, aligned with the sampled MOSI.
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      sclk_sync  <= '1;
      csn_sync   <= '1;
      mosi_sync  <= '0;
      sclk_prev  <= 1'b1;
      csn_prev   <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      csn_fall_q <= 1'b0;
      csn_rise_q <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      csn_sync   <= {csn_sync[SYNC_STAGES-2:0], i_csn};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_prev  <= sclk_s;
      csn_prev   <= csn_s;
      rise_q     <= sclk_s & ~sclk_prev;
      fall_q     <= ~sclk_s & sclk_prev;
      csn_fall_q <= ~csn_s & csn_prev;
      csn_rise_q <= csn_s & ~csn_prev;
      mosi_q     <= mosi_s;
    end
  end

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    stop       = 1'b0;
    rd_go      = 1'b0;
    wr_go      = 1'b0;
    err_go     = 1'b0;
    tx_load    = 1'b0;
    wdata_load = 1'b0;
    if (csn_rise_q && state != IDLE) begin
      state_nxt = IDLE;
      stop      = 1'b1;
      err_go    = (bit_cnt != 5'd0) && (bit_cnt != 5'd16);
    end else begin
      case (state)
        IDLE:  if (csn_fall_q) begin
                 state_nxt = ADDR;
                 start     = 1'b1;
               end
        ADDR:  if (bit_cnt == 5'd8) begin
                 state_nxt = FETCH;
                 rd_go     = 1'b1;
               end
        FETCH: begin
                 state_nxt = DATA;
                 tx_load   = 1'b1;
               end
        DATA:  if (bit_cnt == 5'd16) begin
                 state_nxt  = DONE;
                 wdata_load = 1'b1;
                 wr_go      = ~o_addr[7];
               end
        DONE:  state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign shift_en = rise_q && ((state == ADDR && bit_cnt < 5'd8) ||
                               (state == DATA && bit_cnt < 5'd16));

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      o_miso      <= 1'b0;
      o_miso_oe   <= 1'b0;
      o_addr      <= 8'h00;
      o_rd        <= 1'b0;
      o_wr        <= 1'b0;
      o_wdata     <= 8'h00;
      o_frame_err <= 1'b0;
      bit_cnt     <= 5'd0;
      addr_sr     <= 8'h00;
      rx_sr       <= 8'h00;
      tx_sr       <= 8'h00;
    end else begin
      o_rd        <= rd_go;
      o_wr        <= wr_go;
      o_frame_err <= err_go;
      if (stop) begin
        o_miso_oe <= 1'b0;
        o_miso    <= 1'b0;
        bit_cnt   <= 5'd0;
      end else if (start) begin
        o_miso_oe <= 1'b1;
        o_miso    <= 1'b0;
        bit_cnt   <= 5'd0;
      end else begin
        if (shift_en) begin
          bit_cnt <= bit_cnt + 5'd1;
          if (state == ADDR) addr_sr <= shift_in(addr_sr, mosi_q);
          else               rx_sr   <= shift_in(rx_sr, mosi_q);
        end
        if (fall_q && state == DATA) begin
          o_miso <= tx_sr[7];
          tx_sr  <= {tx_sr[6:0], 1'b0};
        end
        if (rd_go)      o_addr  <= addr_sr;
        if (tx_load)    tx_sr   <= (LSB_FIRST != 0) ? bit_rev(i_rdata) : i_rdata;
        if (wdata_load) o_wdata <= rx_sr;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: an MSB-first and an LSB-first instance driven by a task-level SPI master.
`default_nettype none

module tb_spi_slave_regif;

  localparam int SYNC = 2;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rstn, sclk, csn, csn_l, mosi;
  logic [7:0] rdata;
  logic       miso, miso_oe, rd, wr, frame_err, busy;
  logic [7:0] addr, wdata;
  logic       l_miso, l_miso_oe, l_rd, l_wr, l_frame_err, l_busy;
  logic [7:0] l_addr, l_wdata;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0, wr_cnt = 0, err_cnt = 0, both_cnt = 0, lrd_cnt = 0;
  logic [7:0] rd_addr = 8'h00, wr_data = 8'h00;

  always #5 clk = ~clk;

  spi_slave_regif #(.LSB_FIRST(0), .SYNC_STAGES(SYNC)) dut (
    .i_ck(clk), .i_rstn(rstn), .i_sclk(sclk), .i_csn(csn), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe), .o_addr(addr), .o_rd(rd), .i_rdata(rdata),
    .o_wr(wr), .o_wdata(wdata), .o_frame_err(frame_err), .o_busy(busy)
  );

  spi_slave_regif #(.LSB_FIRST(1), .SYNC_STAGES(SYNC)) dut_lsb (
    .i_ck(clk), .i_rstn(rstn), .i_sclk(sclk), .i_csn(csn_l), .i_mosi(mosi),
    .o_miso(l_miso), .o_miso_oe(l_miso_oe), .o_addr(l_addr), .o_rd(l_rd), .i_rdata(rdata),
    .o_wr(l_wr), .o_wdata(l_wdata), .o_frame_err(l_frame_err), .o_busy(l_busy)
  );

  always @(negedge clk) begin
    if (rd) begin rd_cnt <= rd_cnt + 1; rd_addr <= addr; end
    if (wr) begin wr_cnt <= wr_cnt + 1; wr_data <= wdata; end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (rd && wr) both_cnt <= both_cnt + 1;
    if (l_rd) lrd_cnt <= lrd_cnt + 1;
  end

  task automatic spi_start(input bit sel);
    if (sel) csn_l = 1'b0;
    else     csn   = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bit(input bit sel, input logic b, output logic m);
    sclk = 1'b0;
    mosi = b;
    repeat (HALF) @(negedge clk);
    m = sel ? l_miso : miso;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_frame(input bit sel, input logic [31:0] bits, input int n,
                           output logic [31:0] mi);
    logic m;
    mi = '0;
    spi_start(sel);
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(sel, bits[i], m);
      mi = {mi[30:0], m};
    end
    csn   = 1'b1;
    csn_l = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0; sclk = 1'b1; csn = 1'b1; csn_l = 1'b1; mosi = 1'b0; rdata = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b0)    begin failures++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", miso_oe); end
    checks++; if (addr !== 8'h00)   begin failures++; $display("FAIL reset_addr got=%h exp=00", addr); end
    checks++; if (wdata !== 8'h00)  begin failures++; $display("FAIL reset_wdata got=%h exp=00", wdata); end
    checks++; if ({rd, wr, frame_err, busy} !== 4'b0000)
      begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {rd, wr, frame_err, busy}); end
    rstn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write_frame;
    int r0, w0;
    logic m;
    logic [7:0] mb;
    logic [15:0] bits;
    r0 = rd_cnt; w0 = wr_cnt; rdata = 8'h3C; mb = '0;
    bits = {8'h12, 8'hA5};
    spi_start(0);
    checks++; if (miso_oe !== 1'b1) begin failures++; $display("FAIL frame_oe got=%b exp=1", miso_oe); end
    checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL frame_busy got=%b exp=1", busy); end
    for (int i = 15; i >= 0; i--) begin
      spi_bit(0, bits[i], m);
      if (i < 8) mb = {mb[6:0], m};
    end
    csn = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (rd_cnt - r0 != 1) begin failures++; $display("FAIL wr_frame_rd_count got=%0d exp=1", rd_cnt - r0); end
    checks++; if (rd_addr !== 8'h12) begin failures++; $display("FAIL wr_frame_addr got=%h exp=12", rd_addr); end
    checks++; if (mb !== 8'h3C)      begin failures++; $display("FAIL wr_frame_miso got=%h exp=3c", mb); end
    checks++; if (wr_cnt - w0 != 1)  begin failures++; $display("FAIL wr_frame_wr_count got=%0d exp=1", wr_cnt - w0); end
    checks++; if (wr_data !== 8'hA5) begin failures++; $display("FAIL wr_frame_wdata got=%h exp=a5", wr_data); end
    checks++; if ({miso_oe, busy} !== 2'b00)
      begin failures++; $display("FAIL wr_frame_idle got=%b exp=00", {miso_oe, busy}); end
  endtask

  task automatic test_read_only;
    int r0, w0;
    logic [31:0] mi;
    r0 = rd_cnt; w0 = wr_cnt; rdata = 8'h5A;
    spi_frame(0, {16'h0, 8'h85, 8'h77}, 16, mi);
    checks++; if (rd_cnt - r0 != 1)  begin failures++; $display("FAIL ro_rd_count got=%0d exp=1", rd_cnt - r0); end
    checks++; if (mi[7:0] !== 8'h5A) begin failures++; $display("FAIL ro_miso got=%h exp=5a", mi[7:0]); end
    checks++; if (wr_cnt - w0 != 0)  begin failures++; $display("FAIL ro_wr_count got=%0d exp=0", wr_cnt - w0); end
    checks++; if (wdata !== 8'h77)   begin failures++; $display("FAIL ro_wdata got=%h exp=77", wdata); end
  endtask

  task automatic test_lsb_first;
    int l0;
    logic [31:0] mi;
    l0 = lrd_cnt; rdata = 8'h01;
    spi_frame(1, {16'h0, 8'h48, 8'hC0}, 16, mi);
    checks++; if (lrd_cnt - l0 != 1) begin failures++; $display("FAIL lsb_rd_count got=%0d exp=1", lrd_cnt - l0); end
    checks++; if (l_addr !== 8'h12)  begin failures++; $display("FAIL lsb_addr got=%h exp=12", l_addr); end
    checks++; if (mi[7:0] !== 8'h80) begin failures++; $display("FAIL lsb_miso got=%h exp=80", mi[7:0]); end
    checks++; if (l_wdata !== 8'h03) begin failures++; $display("FAIL lsb_wdata got=%h exp=03", l_wdata); end
  endtask

  task automatic test_abort;
    int e0, w0;
    logic m;
    logic [10:0] bits;
    e0 = err_cnt; w0 = wr_cnt; rdata = 8'h00;
    bits = {8'h34, 3'b101};
    spi_start(0);
    for (int i = 10; i >= 0; i--) spi_bit(0, bits[i], m);
    csn = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    repeat (10) @(negedge clk);
    checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL abort_err_count got=%0d exp=1", err_cnt - e0); end
    checks++; if (wr_cnt - w0 != 0)  begin failures++; $display("FAIL abort_wr_count got=%0d exp=0", wr_cnt - w0); end
  endtask

  task automatic test_long_frame;
    int e0, w0;
    logic [31:0] mi;
    e0 = err_cnt; w0 = wr_cnt;
    spi_frame(0, {12'h0, 8'h21, 8'hC3, 4'hA}, 20, mi);
    checks++; if (wr_cnt - w0 != 1)  begin failures++; $display("FAIL long_wr_count got=%0d exp=1", wr_cnt - w0); end
    checks++; if (wr_data !== 8'hC3) begin failures++; $display("FAIL long_wdata got=%h exp=c3", wr_data); end
    checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL long_err_count got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid_frame;
    int w0;
    logic m;
    logic [11:0] bits;
    logic [31:0] mi;
    w0 = wr_cnt;
    bits = {8'h03, 4'h5};
    spi_start(0);
    for (int i = 11; i >= 0; i--) spi_bit(0, bits[i], m);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({miso, miso_oe, busy} !== 3'b000)
      begin failures++; $display("FAIL rstmid_ctrl got=%b exp=000", {miso, miso_oe, busy}); end
    checks++; if (addr !== 8'h00)  begin failures++; $display("FAIL rstmid_addr got=%h exp=00", addr); end
    checks++; if (wdata !== 8'h00) begin failures++; $display("FAIL rstmid_wdata got=%h exp=00", wdata); end
    csn = 1'b1; sclk = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (wr_cnt - w0 != 0) begin failures++; $display("FAIL rstmid_no_wr got=%0d exp=0", wr_cnt - w0); end
    spi_frame(0, {16'h0, 8'h01, 8'hFF}, 16, mi);
    checks++; if (wr_cnt - w0 != 1)  begin failures++; $display("FAIL rstmid_next_wr got=%0d exp=1", wr_cnt - w0); end
    checks++; if (wr_data !== 8'hFF) begin failures++; $display("FAIL rstmid_next_wdata got=%h exp=ff", wr_data); end
    checks++; if (rd_addr !== 8'h01) begin failures++; $display("FAIL rstmid_next_addr got=%h exp=01", rd_addr); end
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_read_only();
    test_lsb_first();
    test_abort();
    test_long_frame();
    test_reset_mid_frame();
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL rd_wr_overlap got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
